// File: rtl/mem_arbiter_pkg.sv
// Shared widths, state encodings and owner tags for the CPU/loader memory arbiter.
package mem_arbiter_pkg;

  localparam int unsigned DEF_WORD_SIZE     = 16;
  localparam int unsigned DEF_MEM_ADDR_SIZE = 16;
  localparam int unsigned DEF_STARVE_LIMIT  = 4;
  localparam int unsigned STARVE_CNT_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_DONE   = 2'b10
  } arb_state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_LDR = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of cycles the loader has waited; flags when the limit is reached.
module arb_starve_counter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned LIMIT = DEF_STARVE_LIMIT
) (
  input  logic i_clock,
  input  logic i_reset_n,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_limit_hit_c
);

  logic [STARVE_CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt < STARVE_CNT_W'(LIMIT))) begin
      r_cnt <= r_cnt + STARVE_CNT_W'(1);
    end
  end

  assign o_limit_hit_c = (r_cnt == STARVE_CNT_W'(LIMIT));

endmodule

// File: rtl/mem_arbiter.sv
// Two-master (CPU, loader) single-port memory arbiter: one access per two cycles,
// CPU priority with a starvation override for the loader.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned WORD_SIZE     = DEF_WORD_SIZE,
  parameter int unsigned MEM_ADDR_SIZE = DEF_MEM_ADDR_SIZE,
  parameter int unsigned STARVE_LIMIT  = DEF_STARVE_LIMIT
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     cpu_read,
  input  logic                     cpu_write,
  input  logic [MEM_ADDR_SIZE-1:0] cpu_address,
  input  logic [WORD_SIZE-1:0]     cpu_write_data,
  output logic [WORD_SIZE-1:0]     cpu_read_data,
  output logic                     cpu_ready,
  output logic                     cpu_stall,
  input  logic                     ldr_req,
  input  logic                     ldr_write,
  input  logic [MEM_ADDR_SIZE-1:0] ldr_address,
  input  logic [WORD_SIZE-1:0]     ldr_write_data,
  output logic [WORD_SIZE-1:0]     ldr_read_data,
  output logic                     ldr_ready,
  output logic [MEM_ADDR_SIZE-1:0] mem_address,
  output logic [WORD_SIZE-1:0]     mem_write_data,
  output logic                     mem_read,
  output logic                     mem_write,
  input  logic [WORD_SIZE-1:0]     mem_read_data,
  output logic                     proto_err
);

  arb_state_e r_state;
  arb_state_e w_state_nxt;
  arb_owner_e r_owner;
  arb_owner_e w_owner_nxt;

  logic                     w_cpu_req;
  logic                     w_arb;
  logic                     w_limit_hit;
  logic                     w_grant_ldr;
  logic                     w_grant_cpu;
  logic                     w_ldr_in_access;

  logic [MEM_ADDR_SIZE-1:0] w_addr_nxt;
  logic [WORD_SIZE-1:0]     w_wdata_nxt;
  logic                     w_mem_read_nxt;
  logic                     w_mem_write_nxt;
  logic                     w_cpu_ready_nxt;
  logic                     w_ldr_ready_nxt;
  logic                     w_cap_cpu;
  logic                     w_cap_ldr;

  logic [MEM_ADDR_SIZE-1:0] r_mem_address;
  logic [WORD_SIZE-1:0]     r_mem_write_data;
  logic                     r_mem_read;
  logic                     r_mem_write;
  logic                     r_cpu_ready;
  logic                     r_ldr_ready;
  logic [WORD_SIZE-1:0]     r_cpu_read_data;
  logic [WORD_SIZE-1:0]     r_ldr_read_data;
  logic                     r_proto_err;

  // Arbitration happens in IDLE and DONE; the loader only beats the CPU once starved.
  assign w_cpu_req       = cpu_read | cpu_write;
  assign w_arb           = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_grant_ldr     = w_arb && ldr_req && (!w_cpu_req || w_limit_hit);
  assign w_grant_cpu     = w_arb && w_cpu_req && !w_grant_ldr;
  assign w_ldr_in_access = (r_state == ST_ACCESS) && (r_owner == OWN_LDR);

  arb_starve_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .i_clock       (clock),
    .i_reset_n     (reset),
    .i_clear       (w_grant_ldr | ~ldr_req),
    .i_inc         (ldr_req & ~w_ldr_in_access),
    .o_limit_hit_c (w_limit_hit)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = ST_IDLE;
    unique case (r_state)
      ST_IDLE, ST_DONE: w_state_nxt = (w_cpu_req || ldr_req) ? ST_ACCESS : ST_IDLE;
      ST_ACCESS:        w_state_nxt = ST_DONE;
      default:          w_state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs, decided by the current state.
  always_comb begin
    w_owner_nxt     = r_owner;
    w_addr_nxt      = r_mem_address;
    w_wdata_nxt     = r_mem_write_data;
    w_mem_read_nxt  = 1'b0;
    w_mem_write_nxt = 1'b0;
    w_cpu_ready_nxt = 1'b0;
    w_ldr_ready_nxt = 1'b0;
    w_cap_cpu       = 1'b0;
    w_cap_ldr       = 1'b0;
    unique case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_grant_ldr) begin
          w_owner_nxt     = OWN_LDR;
          w_addr_nxt      = ldr_address;
          w_wdata_nxt     = ldr_write_data;
          w_mem_write_nxt = ldr_write;
          w_mem_read_nxt  = !ldr_write;
        end else if (w_grant_cpu) begin
          w_owner_nxt     = OWN_CPU;
          w_addr_nxt      = cpu_address;
          w_wdata_nxt     = cpu_write_data;
          w_mem_write_nxt = cpu_write;
          w_mem_read_nxt  = !cpu_write;
        end
      end
      ST_ACCESS: begin
        w_cpu_ready_nxt = (r_owner == OWN_CPU);
        w_ldr_ready_nxt = (r_owner == OWN_LDR);
        w_cap_cpu       = (r_owner == OWN_CPU) && r_mem_read;
        w_cap_ldr       = (r_owner == OWN_LDR) && r_mem_read;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_owner          <= OWN_CPU;
      r_mem_address    <= '0;
      r_mem_write_data <= '0;
      r_mem_read       <= 1'b0;
      r_mem_write      <= 1'b0;
      r_cpu_ready      <= 1'b0;
      r_ldr_ready      <= 1'b0;
      r_cpu_read_data  <= '0;
      r_ldr_read_data  <= '0;
      r_proto_err      <= 1'b0;
    end else begin
      r_owner          <= w_owner_nxt;
      r_mem_address    <= w_addr_nxt;
      r_mem_write_data <= w_wdata_nxt;
      r_mem_read       <= w_mem_read_nxt;
      r_mem_write      <= w_mem_write_nxt;
      r_cpu_ready      <= w_cpu_ready_nxt;
      r_ldr_ready      <= w_ldr_ready_nxt;
      if (w_cap_cpu) r_cpu_read_data <= mem_read_data;
      if (w_cap_ldr) r_ldr_read_data <= mem_read_data;
      r_proto_err      <= r_proto_err | (cpu_read & cpu_write);
    end
  end

  assign cpu_stall      = w_cpu_req & ~r_cpu_ready;
  assign cpu_read_data  = r_cpu_read_data;
  assign cpu_ready      = r_cpu_ready;
  assign ldr_read_data  = r_ldr_read_data;
  assign ldr_ready      = r_ldr_ready;
  assign mem_address    = r_mem_address;
  assign mem_write_data = r_mem_write_data;
  assign mem_read       = r_mem_read;
  assign mem_write      = r_mem_write;
  assign proto_err      = r_proto_err;

endmodule
